// File: rtl/fft_frame_buffer.sv
// Ping-pong frame buffer ahead of the FFT butterflies: one bank fills from the
// input stream (bit-reversed or natural order, zero-padded on early tlast) while the other replays.
module fft_frame_buffer #(
   parameter int N_POINTS    = 8,
   parameter int DATA_W      = 50,
   parameter bit BIT_REVERSE = 1'b1
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic                      s_tvalid,
   output logic                      s_tready,
   input  logic                      s_tlast,
   input  logic [DATA_W-1:0]         s_tdata,
   output logic                      m_tvalid,
   input  logic                      m_tready,
   output logic                      m_tlast,
   output logic [DATA_W-1:0]         m_tdata,
   output logic [$clog2(N_POINTS):0] m_len
);

   localparam int LOG2N = $clog2(N_POINTS);
   localparam int LEN_W = LOG2N + 1;
   localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N_POINTS - 1);
   localparam logic [LOG2N-1:0] CNT_ONE  = LOG2N'(1);
   localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(N_POINTS);
   localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

   typedef enum logic [0:0] {W_FILL, W_PAD} wr_state_e;
   typedef enum logic [1:0] {R_IDLE, R_READ, R_LAST} rd_state_e;

   function automatic logic [LOG2N-1:0] map_addr(input logic [LOG2N-1:0] idx);
      logic [LOG2N-1:0] rev;
      rev = idx;
      for (int b = 0; b < LOG2N; b++) begin
         rev[b] = idx[LOG2N-1-b];
      end
      return BIT_REVERSE ? rev : idx;
   endfunction

   logic [DATA_W-1:0] mem_q [2*N_POINTS];

   wr_state_e                 wr_state_q, wr_state_d;
   logic [LOG2N-1:0]          wr_cnt_q, wr_cnt_d;
   logic                      wr_bank_q, wr_bank_d;
   logic [LEN_W-1:0]          wr_len_q, wr_len_d;
   logic [1:0]                full_q, full_d;
   logic [1:0][LEN_W-1:0]     len_q, len_d;

   rd_state_e                 rd_state_q, rd_state_d;
   logic [LOG2N-1:0]          rd_cnt_q, rd_cnt_d;
   logic                      rd_bank_q, rd_bank_d;
   logic                      m_tvalid_q, m_tvalid_d;
   logic                      m_tlast_q, m_tlast_d;
   logic [LEN_W-1:0]          m_len_q, m_len_d;
   logic [DATA_W-1:0]         m_tdata_q;

   logic                      s_tready_c;
   logic                      mem_we;
   logic [DATA_W-1:0]         mem_wdata;
   logic [LOG2N:0]            mem_waddr;
   logic                      wr_close;
   logic [LEN_W-1:0]          close_len;
   logic                      rd_load;
   logic                      rd_load_bank;
   logic [LOG2N-1:0]          rd_load_addr;
   logic                      rd_free;
   logic                      out_adv;

   // Write side: fill, then pad with zeros after an early tlast, then close the bank.
   always_comb begin
      wr_state_d = wr_state_q;
      wr_cnt_d   = wr_cnt_q;
      wr_bank_d  = wr_bank_q;
      wr_len_d   = wr_len_q;
      len_d      = len_q;
      s_tready_c = 1'b0;
      mem_we     = 1'b0;
      mem_wdata  = '0;
      wr_close   = 1'b0;
      close_len  = FULL_LEN;
      mem_waddr  = {wr_bank_q, map_addr(wr_cnt_q)};
      case (wr_state_q)
         W_FILL: begin
            s_tready_c = ~full_q[wr_bank_q];
            if (s_tready_c && s_tvalid) begin
               mem_we    = 1'b1;
               mem_wdata = s_tdata;
               wr_cnt_d  = wr_cnt_q + CNT_ONE;
               if (wr_cnt_q == LAST_IDX) begin
                  wr_close = 1'b1;
               end else if (s_tlast) begin
                  wr_state_d = W_PAD;
                  wr_len_d   = {1'b0, wr_cnt_q} + LEN_ONE;
               end
            end
         end
         W_PAD: begin
            mem_we   = 1'b1;
            wr_cnt_d = wr_cnt_q + CNT_ONE;
            if (wr_cnt_q == LAST_IDX) begin
               wr_close   = 1'b1;
               close_len  = wr_len_q;
               wr_state_d = W_FILL;
            end
         end
         default: wr_state_d = W_FILL;
      endcase
      if (wr_close) begin
         wr_cnt_d          = '0;
         wr_bank_d         = ~wr_bank_q;
         len_d[wr_bank_q]  = close_len;
      end
   end

   assign s_tready = s_tready_c & ~reset_i;

   // Read side: the output register doubles as the one-cycle memory read stage.
   always_comb begin
      out_adv      = ~m_tvalid_q | m_tready;
      rd_state_d   = rd_state_q;
      rd_cnt_d     = rd_cnt_q;
      rd_bank_d    = rd_bank_q;
      m_tvalid_d   = m_tvalid_q;
      m_tlast_d    = m_tlast_q;
      m_len_d      = m_len_q;
      rd_load      = 1'b0;
      rd_load_bank = rd_bank_q;
      rd_load_addr = rd_cnt_q;
      rd_free      = 1'b0;
      case (rd_state_q)
         R_IDLE: begin
            if (full_q[rd_bank_q]) begin
               rd_load      = 1'b1;
               rd_load_addr = '0;
               m_tvalid_d   = 1'b1;
               m_tlast_d    = 1'b0;
               m_len_d      = len_q[rd_bank_q];
               rd_cnt_d     = CNT_ONE;
               rd_state_d   = R_READ;
            end
         end
         R_READ: begin
            if (out_adv) begin
               rd_load   = 1'b1;
               m_tlast_d = (rd_cnt_q == LAST_IDX);
               rd_cnt_d  = rd_cnt_q + CNT_ONE;
               if (rd_cnt_q == LAST_IDX) begin
                  rd_state_d = R_LAST;
               end
            end
         end
         R_LAST: begin
            if (m_tready) begin
               rd_free   = 1'b1;
               rd_bank_d = ~rd_bank_q;
               // Chain straight into the other bank when it is already waiting.
               if (full_q[~rd_bank_q]) begin
                  rd_load      = 1'b1;
                  rd_load_bank = ~rd_bank_q;
                  rd_load_addr = '0;
                  m_tlast_d    = 1'b0;
                  m_len_d      = len_q[~rd_bank_q];
                  rd_cnt_d     = CNT_ONE;
                  rd_state_d   = R_READ;
               end else begin
                  m_tvalid_d = 1'b0;
                  m_tlast_d  = 1'b0;
                  rd_cnt_d   = '0;
                  rd_state_d = R_IDLE;
               end
            end
         end
         default: rd_state_d = R_IDLE;
      endcase
   end

   always_comb begin
      full_d = full_q;
      if (wr_close) full_d[wr_bank_q] = 1'b1;
      if (rd_free)  full_d[rd_bank_q] = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_state_q <= W_FILL;
         wr_cnt_q   <= '0;
         wr_bank_q  <= 1'b0;
         wr_len_q   <= '0;
         full_q     <= '0;
         len_q      <= '0;
         rd_state_q <= R_IDLE;
         rd_cnt_q   <= '0;
         rd_bank_q  <= 1'b0;
         m_tvalid_q <= 1'b0;
         m_tlast_q  <= 1'b0;
         m_len_q    <= '0;
      end else begin
         wr_state_q <= wr_state_d;
         wr_cnt_q   <= wr_cnt_d;
         wr_bank_q  <= wr_bank_d;
         wr_len_q   <= wr_len_d;
         full_q     <= full_d;
         len_q      <= len_d;
         rd_state_q <= rd_state_d;
         rd_cnt_q   <= rd_cnt_d;
         rd_bank_q  <= rd_bank_d;
         m_tvalid_q <= m_tvalid_d;
         m_tlast_q  <= m_tlast_d;
         m_len_q    <= m_len_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         m_tdata_q <= '0;
      end else if (rd_load) begin
         m_tdata_q <= mem_q[{rd_load_bank, rd_load_addr}];
      end
   end

   always_ff @(posedge clk_i) begin
      if (mem_we && !reset_i) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   assign m_tvalid = m_tvalid_q;
   assign m_tlast  = m_tlast_q;
   assign m_tdata  = m_tdata_q;
   assign m_len    = m_len_q;

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Directed bench for fft_frame_buffer: a bit-reversed and a natural-order
// instance share one input stream; each output stream is compared against hand-built frames.
module tb_fft_frame_buffer;

   localparam int BRT [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

   typedef struct {
      logic [49:0] d;
      logic        l;
      logic [3:0]  n;
   } item_t;

   logic        clk = 1'b0;
   logic        reset_i = 1'b1;
   logic        s_tvalid = 1'b0;
   logic        s_tlast = 1'b0;
   logic [49:0] s_tdata = '0;
   logic        m_tready = 1'b0;

   logic        br_s_tready, br_m_tvalid, br_m_tlast;
   logic [49:0] br_m_tdata;
   logic [3:0]  br_m_len;
   logic        nat_s_tready, nat_m_tvalid, nat_m_tlast;
   logic [49:0] nat_m_tdata;
   logic [3:0]  nat_m_len;

   int checks = 0;
   int failures = 0;
   int hold_err = 0;
   int hold_cnt = 0;
   int rdy_err = 0;
   int br_base = 0;
   int nat_base = 0;
   logic tx_done = 1'b0;

   item_t br_q[$];
   item_t nat_q[$];
   item_t exp_br[$];
   item_t exp_nat[$];

   fft_frame_buffer #(.N_POINTS(8), .DATA_W(50), .BIT_REVERSE(1'b1)) u_br (
      .clk_i(clk), .reset_i(reset_i),
      .s_tvalid(s_tvalid), .s_tready(br_s_tready), .s_tlast(s_tlast), .s_tdata(s_tdata),
      .m_tvalid(br_m_tvalid), .m_tready(m_tready), .m_tlast(br_m_tlast),
      .m_tdata(br_m_tdata), .m_len(br_m_len)
   );

   fft_frame_buffer #(.N_POINTS(8), .DATA_W(50), .BIT_REVERSE(1'b0)) u_nat (
      .clk_i(clk), .reset_i(reset_i),
      .s_tvalid(s_tvalid), .s_tready(nat_s_tready), .s_tlast(s_tlast), .s_tdata(s_tdata),
      .m_tvalid(nat_m_tvalid), .m_tready(m_tready), .m_tlast(nat_m_tlast),
      .m_tdata(nat_m_tdata), .m_len(nat_m_len)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Output capture plus hold-while-stalled tracking, sampled on the falling edge.
   initial begin : collector
      logic        prev_stall;
      logic [49:0] prev_d;
      logic        prev_l;
      logic [3:0]  prev_n;
      item_t       it;
      prev_stall = 1'b0;
      prev_d = '0;
      prev_l = 1'b0;
      prev_n = '0;
      forever begin
         @(negedge clk);
         if (reset_i) begin
            prev_stall = 1'b0;
         end else begin
            if (br_s_tready !== nat_s_tready) rdy_err++;
            if (prev_stall) begin
               hold_cnt++;
               if (br_m_tvalid !== 1'b1 || br_m_tdata !== prev_d ||
                   br_m_tlast !== prev_l || br_m_len !== prev_n) hold_err++;
            end
            if (br_m_tvalid && m_tready) begin
               it.d = br_m_tdata; it.l = br_m_tlast; it.n = br_m_len;
               br_q.push_back(it);
            end
            if (nat_m_tvalid && m_tready) begin
               it.d = nat_m_tdata; it.l = nat_m_tlast; it.n = nat_m_len;
               nat_q.push_back(it);
            end
            prev_stall = br_m_tvalid && !m_tready;
            prev_d = br_m_tdata;
            prev_l = br_m_tlast;
            prev_n = br_m_len;
         end
      end
   end

   task automatic send(input int d, input logic l);
      int n;
      n = 0;
      s_tvalid = 1'b1;
      s_tdata  = 50'(d);
      s_tlast  = l;
      @(negedge clk);
      while (!br_s_tready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("send_ready", 64'(br_s_tready), 64'(1));
      @(posedge clk);
      #1;
   endtask

   task automatic s_idle();
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic push_frame(input int base, input int len);
      item_t e;
      for (int a = 0; a < 8; a++) begin
         e.l = (a == 7);
         e.n = 4'(len);
         e.d = (BRT[a] < len) ? 50'(base + BRT[a]) : 50'(0);
         exp_br.push_back(e);
         e.d = (a < len) ? 50'(base + a) : 50'(0);
         exp_nat.push_back(e);
      end
   endtask

   task automatic wait_q(input int n);
      int c;
      c = 0;
      while (((br_q.size() - br_base) < n || (nat_q.size() - nat_base) < n) && c < 400) begin
         @(negedge clk);
         c++;
      end
   endtask

   task automatic compare(input string tag);
      chk({tag, "_br_count"}, 64'(br_q.size() - br_base), 64'(exp_br.size()));
      chk({tag, "_nat_count"}, 64'(nat_q.size() - nat_base), 64'(exp_nat.size()));
      for (int k = 0; k < exp_br.size() && (br_base + k) < br_q.size(); k++) begin
         chk($sformatf("%s_br_data%0d", tag, k), 64'(br_q[br_base+k].d), 64'(exp_br[k].d));
         chk($sformatf("%s_br_last%0d", tag, k), 64'(br_q[br_base+k].l), 64'(exp_br[k].l));
         chk($sformatf("%s_br_len%0d", tag, k), 64'(br_q[br_base+k].n), 64'(exp_br[k].n));
      end
      for (int k = 0; k < exp_nat.size() && (nat_base + k) < nat_q.size(); k++) begin
         chk($sformatf("%s_nat_data%0d", tag, k), 64'(nat_q[nat_base+k].d), 64'(exp_nat[k].d));
         chk($sformatf("%s_nat_last%0d", tag, k), 64'(nat_q[nat_base+k].l), 64'(exp_nat[k].l));
         chk($sformatf("%s_nat_len%0d", tag, k), 64'(nat_q[nat_base+k].n), 64'(exp_nat[k].n));
      end
      br_base  = br_q.size();
      nat_base = nat_q.size();
      exp_br.delete();
      exp_nat.delete();
   endtask

   initial begin : stim
      int found;
      // Reset state
      @(negedge clk);
      chk("rst_s_tready_low", 64'(br_s_tready), 64'(0));
      @(posedge clk); #1;
      reset_i = 1'b0;
      @(negedge clk);
      chk("rst_s_tready", 64'(br_s_tready), 64'(1));
      chk("rst_m_tvalid", 64'(br_m_tvalid), 64'(0));
      chk("rst_m_tlast", 64'(br_m_tlast), 64'(0));
      chk("rst_m_tdata", 64'(br_m_tdata), 64'(0));
      chk("rst_m_len", 64'(br_m_len), 64'(0));

      // 1: full frame, bit-reversed replay, two-cycle latency
      @(posedge clk); #1;
      m_tready = 1'b1;
      for (int i = 1; i <= 8; i++) send(i, i == 8);
      s_idle();
      @(negedge clk);
      chk("t1_lat_t1_valid", 64'(br_m_tvalid), 64'(0));
      @(negedge clk);
      chk("t1_lat_t2_valid", 64'(br_m_tvalid), 64'(1));
      chk("t1_lat_t2_data", 64'(br_m_tdata), 64'(1));
      push_frame(1, 8);
      wait_q(8);
      compare("t1");

      // 2: short frame, five pad cycles
      @(posedge clk); #1;
      for (int i = 1; i <= 3; i++) send(i, i == 3);
      s_idle();
      for (int p = 0; p < 5; p++) begin
         @(negedge clk);
         chk($sformatf("t2_pad_ready%0d", p), 64'(br_s_tready), 64'(0));
      end
      @(negedge clk);
      chk("t2_ready_after_pad", 64'(br_s_tready), 64'(1));
      push_frame(1, 3);
      wait_q(8);
      compare("t2");

      // 3: both banks fill with the output stalled
      @(posedge clk); #1;
      m_tready = 1'b0;
      for (int i = 1; i <= 16; i++) send(i, i == 8 || i == 16);
      s_idle();
      @(negedge clk);
      chk("t3_full_ready", 64'(br_s_tready), 64'(0));
      chk("t3_stall_valid", 64'(br_m_tvalid), 64'(1));
      chk("t3_stall_data", 64'(br_m_tdata), 64'(1));
      chk("t3_stall_len", 64'(br_m_len), 64'(8));
      repeat (3) @(negedge clk);
      chk("t3_still_full", 64'(br_s_tready), 64'(0));
      @(posedge clk); #1;
      m_tready = 1'b1;
      found = 0;
      for (int c = 0; c < 30 && found == 0; c++) begin
         @(negedge clk);
         if (br_m_tvalid && br_m_tlast) found = 1;
      end
      chk("t3_tlast_seen", 64'(found), 64'(1));
      chk("t3_ready_at_tlast", 64'(br_s_tready), 64'(0));
      @(negedge clk);
      chk("t3_ready_after_tlast", 64'(br_s_tready), 64'(1));
      chk("t3_next_valid", 64'(br_m_tvalid), 64'(1));
      chk("t3_next_data", 64'(br_m_tdata), 64'(9));
      push_frame(1, 8);
      push_frame(9, 8);
      wait_q(16);
      compare("t3");

      // 4: twenty frames, some short, with random output backpressure
      @(posedge clk); #1;
      tx_done = 1'b0;
      fork
         begin
            for (int f = 0; f < 20; f++) begin
               int len;
               len = (f % 4 == 3) ? (f % 7) + 1 : 8;
               push_frame(f * 16 + 1, len);
               for (int i = 0; i < len; i++) begin
                  if (f % 5 == 0 && i == 2) begin
                     s_idle();
                     @(posedge clk); #1;
                  end
                  send(f * 16 + 1 + i, i == len - 1);
               end
            end
            s_idle();
            tx_done = 1'b1;
         end
         begin
            int cyc;
            cyc = 0;
            while (!(tx_done && (br_q.size() - br_base) >= 160) && cyc < 4000) begin
               @(posedge clk); #2;
               m_tready = 1'($urandom_range(0, 1));
               cyc++;
            end
         end
      join
      @(posedge clk); #1;
      m_tready = 1'b1;
      wait_q(160);
      compare("t4");

      // 5: reset in the middle of a frame with an output pending
      @(posedge clk); #1;
      m_tready = 1'b0;
      for (int i = 201; i <= 208; i++) send(i, i == 208);
      for (int i = 101; i <= 104; i++) send(i, 1'b0);
      s_idle();
      repeat (2) @(negedge clk);
      chk("t5_pending_valid", 64'(br_m_tvalid), 64'(1));
      @(posedge clk); #1;
      reset_i = 1'b1;
      @(negedge clk);
      chk("t5_rst_ready_low", 64'(br_s_tready), 64'(0));
      @(posedge clk); #1;
      reset_i = 1'b0;
      @(negedge clk);
      chk("t5_valid_dropped", 64'(br_m_tvalid), 64'(0));
      chk("t5_ready_back", 64'(br_s_tready), 64'(1));
      br_base  = br_q.size();
      nat_base = nat_q.size();
      @(posedge clk); #1;
      m_tready = 1'b1;
      for (int i = 21; i <= 28; i++) send(i, i == 28);
      s_idle();
      push_frame(21, 8);
      wait_q(8);
      repeat (12) @(negedge clk);
      compare("t5");

      // 6: sixteen samples, no tlast
      @(posedge clk); #1;
      for (int i = 1; i <= 16; i++) send(i, 1'b0);
      s_idle();
      push_frame(1, 8);
      push_frame(9, 8);
      wait_q(16);
      compare("t6");

      chk("hold_stable", 64'(hold_err), 64'(0));
      chk("hold_seen", 64'(hold_cnt > 0), 64'(1));
      chk("ready_agree", 64'(rdy_err), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
